// File: rtl/saber_wb_pkg.sv
// Shared constants and FSM encoding for the Saber polynomial accumulator writeback path.
package saber_wb_pkg;

  localparam int N_COEFF   = 256;
  localparam int LANES     = 4;
  localparam int WORDS     = 64;
  localparam int EQ        = 13;
  localparam int EP        = 10;
  localparam int LANE_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

  // Lane arithmetic is carried in EQ bits; the 10-bit mode just masks it down.
  function automatic logic [EQ-1:0] lane_mask(input logic coeff16);
    return coeff16 ? EQ'((1 << EP) - 1) : EQ'((1 << EQ) - 1);
  endfunction

endpackage

// File: rtl/lane_round_add.sv
// One coefficient lane: optional add of the stored value, wrap to the lane width,
// optional Saber rounding (add constant, shift right), zero-extend to 16 bits.
module lane_round_add
  import saber_wb_pkg::*;
#(
  parameter int SHIFT       = 3,
  parameter int ROUND_CONST = 4
) (
  input  logic [EQ-1:0]        coeff,
  input  logic [EQ-1:0]        prev,
  input  logic                 acc_en,
  input  logic                 round_en,
  input  logic                 coeff16,
  output logic [LANE_BITS-1:0] result
);

  localparam logic [EQ-1:0] RC = EQ'(ROUND_CONST);

  logic [EQ-1:0] mask;
  logic [EQ-1:0] addend;
  logic [EQ-1:0] sum;
  logic [EQ-1:0] rounded;
  logic [EQ-1:0] shifted;

  // Masking after each add gives the mod 2^W wrap for either lane width.
  always_comb begin
    mask    = lane_mask(coeff16);
    addend  = acc_en ? prev : '0;
    sum     = (coeff + addend) & mask;
    rounded = (sum + RC) & mask;
    shifted = rounded >> SHIFT;
    result  = {{(LANE_BITS - EQ){1'b0}}, (round_en ? shifted : sum)};
  end

endmodule

// File: rtl/poly_acc_writeback.sv
// Drains the multiplier accumulator four coefficients per cycle, optionally
// accumulates onto the stored polynomial and rounds, and writes 64 BRAM words.
module poly_acc_writeback
  import saber_wb_pkg::*;
#(
  parameter int SHIFT       = 3,
  parameter int ROUND_CONST = 4,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              acc_mode,
  input  logic              round_en,
  input  logic              coeff16,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mul_done,
  output logic              mul_read,
  output logic              mul_acc_clear,
  input  logic [63:0]       coeff4x_in,
  output logic [ADDR_W-1:0] prev_addr,
  input  logic [63:0]       prev_rdata,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [63:0]       wr_data,
  output logic              wr_en,
  output logic              done
);

  localparam int            KW     = $clog2(WORDS);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  wb_state_e         state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic              drain_q, drain_d;
  logic              acc_mode_q, acc_mode_d;
  logic              round_en_q, round_en_d;
  logic              coeff16_q, coeff16_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic                     s1_valid_q, s1_valid_d;
  logic [LANES-1:0][EQ-1:0] s1_lane_q, s1_lane_d;
  logic [KW-1:0]            s1_k_q, s1_k_d;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [63:0]       wr_data_q, wr_data_d;

  logic [LANES-1:0][LANE_BITS-1:0] lane_res;
  logic [LANES-1:0][EQ-1:0]        prev_lane;
  logic                            unused_hi_bits;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    drain_d    = drain_q;
    acc_mode_d = acc_mode_q;
    round_en_d = round_en_q;
    coeff16_d  = coeff16_q;
    base_d     = base_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && mul_done) begin
          state_d    = ST_RUN;
          k_d        = '0;
          acc_mode_d = acc_mode;
          round_en_d = round_en;
          coeff16_d  = coeff16;
          base_d     = base_addr;
        end
      end
      ST_RUN: begin
        if (k_q == K_LAST) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q) begin
          state_d = ST_DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      drain_q    <= 1'b0;
      acc_mode_q <= 1'b0;
      round_en_q <= 1'b0;
      coeff16_q  <= 1'b0;
      base_q     <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      drain_q    <= drain_d;
      acc_mode_q <= acc_mode_d;
      round_en_q <= round_en_d;
      coeff16_q  <= coeff16_d;
      base_q     <= base_d;
    end
  end

  // Control outputs decode the state register so reset clears them without a clock.
  assign mul_read      = (state_q == ST_RUN);
  assign done          = (state_q == ST_DONE);
  assign mul_acc_clear = (state_q == ST_DONE);
  assign prev_addr     = mul_read ? (base_q + ADDR_W'(k_q)) : '0;

  always_comb begin
    s1_valid_d = mul_read;
    s1_k_d     = k_q;
    s1_lane_d  = s1_lane_q;
    if (mul_read) begin
      for (int i = 0; i < LANES; i++) begin
        s1_lane_d[i] = coeff4x_in[LANE_BITS*i +: EQ];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prev_lane[i] = prev_rdata[LANE_BITS*i +: EQ];
    end
  end

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      lane_round_add #(
        .SHIFT       (SHIFT),
        .ROUND_CONST (ROUND_CONST)
      ) u_lane (
        .coeff    (s1_lane_q[g]),
        .prev     (prev_lane[g]),
        .acc_en   (acc_mode_q),
        .round_en (round_en_q),
        .coeff16  (coeff16_q),
        .result   (lane_res[g])
      );
    end
  endgenerate

  // Stage 2 combines stage-1 lanes with the BRAM word that arrived this cycle.
  always_comb begin
    wr_en_d   = s1_valid_q;
    wr_addr_d = s1_valid_q ? (base_q + ADDR_W'(s1_k_q)) : '0;
    wr_data_d = s1_valid_q ? lane_res : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_lane_q  <= '0;
      s1_k_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lane_q  <= s1_lane_d;
      s1_k_q     <= s1_k_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  assign unused_hi_bits = ^{coeff4x_in[15:13], coeff4x_in[31:29], coeff4x_in[47:45],
                            coeff4x_in[63:61], prev_rdata[15:13], prev_rdata[31:29],
                            prev_rdata[47:45], prev_rdata[63:61]};

endmodule

// File: tb/tb_poly_acc_writeback.sv
// Randomized bench for poly_acc_writeback: a multiplier/BRAM stand-in plus an
// arithmetic reference model of the stored polynomial.
module tb_poly_acc_writeback;

  localparam int SHIFT = 3;
  localparam int RC    = 4;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          acc_mode = 1'b0;
  logic          round_en = 1'b0;
  logic          coeff16 = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          mul_done = 1'b0;
  logic          mul_read, mul_acc_clear, wr_en, done;
  logic [63:0]   coeff4x_in, prev_rdata, wr_data;
  logic [AW-1:0] prev_addr, wr_addr;

  int errors = 0;
  int checks = 0;

  logic [63:0] bram [256] = '{default: 64'h0};
  logic [63:0] ref_mem [256];
  logic [63:0] coef_tab [64];
  logic [5:0]  rot_idx;

  always #5 clk = ~clk;

  poly_acc_writeback #(.SHIFT(SHIFT), .ROUND_CONST(RC), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .acc_mode      (acc_mode),
    .round_en      (round_en),
    .coeff16       (coeff16),
    .base_addr     (base_addr),
    .mul_done      (mul_done),
    .mul_read      (mul_read),
    .mul_acc_clear (mul_acc_clear),
    .coeff4x_in    (coeff4x_in),
    .prev_addr     (prev_addr),
    .prev_rdata    (prev_rdata),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .done          (done)
  );

  // Multiplier stand-in: each read advances one word through the rotating accumulator.
  assign coeff4x_in = coef_tab[rot_idx];
  always @(posedge clk or posedge rst) begin
    if (rst) rot_idx <= '0;
    else if (mul_read) rot_idx <= rot_idx + 6'd1;
  end

  always @(posedge clk) begin
    if (wr_en) bram[wr_addr] <= wr_data;
    prev_rdata <= bram[prev_addr];
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int model_lane(input int c, input int p, input bit acc, input bit rnd, input bit c16);
    int m, s;
    m = c16 ? 1024 : 8192;
    s = ((c % m) + (acc ? (p % m) : 0)) % m;
    if (rnd) return ((s + RC) % m) >> SHIFT;
    return s;
  endfunction

  function automatic logic [63:0] model_word(input logic [63:0] c, input logic [63:0] p,
                                             input bit acc, input bit rnd, input bit c16);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[16*i +: 16] = 16'(model_lane(int'(c[16*i +: 16]), int'(p[16*i +: 16]), acc, rnd, c16));
    end
    return r;
  endfunction

  task automatic applyStimulus(input bit acc, input bit rnd, input bit c16, input logic [7:0] base,
                               input bit fresh, input bit use_w0, input logic [63:0] w0,
                               input int abort_cyc,
                               output logic [63:0] obs0, output logic [7:0] last_addr);
    logic [63:0] exp_q [64];
    int nwr, nrd, ndone;
    bit aborted;
    nwr = 0; nrd = 0; ndone = 0; aborted = 0;
    obs0 = '0; last_addr = '0;
    if (fresh) begin
      for (int k = 0; k < 64; k++) coef_tab[k] = {$urandom, $urandom};
      if (use_w0) coef_tab[0] = w0;
    end
    for (int k = 0; k < 64; k++) begin
      exp_q[k] = model_word(coef_tab[k], ref_mem[8'(base + 8'(k))], acc, rnd, c16);
    end
    @(negedge clk);
    acc_mode = acc; round_en = rnd; coeff16 = c16; base_addr = base;
    mul_done = 1'b1; start = 1'b1;
    @(posedge clk);
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      start     = (cyc == 10);
      acc_mode  = 1'($urandom);
      round_en  = 1'($urandom);
      coeff16   = 1'($urandom);
      base_addr = 8'($urandom);
      if (cyc == abort_cyc) begin
        rst = 1'b1;
        #1;
        checkOutput("abort_wr_en", 64'(wr_en), 64'd0);
        checkOutput("abort_mul_read", 64'(mul_read), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_acc_clear", 64'(mul_acc_clear), 64'd0);
        checkOutput("abort_wr_data", wr_data, 64'd0);
        checkOutput("abort_wr_addr", 64'(wr_addr), 64'd0);
        checkOutput("abort_prev_addr", 64'(prev_addr), 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        aborted = 1;
        break;
      end
      if (mul_read) begin
        checkOutput("read_cycle", 64'(cyc), 64'(nrd));
        checkOutput("prev_addr", 64'(prev_addr), 64'(8'(base + 8'(nrd))));
        nrd++;
      end
      if (wr_en) begin
        if (nwr == 0) begin
          obs0 = wr_data;
          checkOutput("first_wr_cycle", 64'(cyc), 64'd2);
        end
        if (nwr < 64) begin
          checkOutput("wr_addr", 64'(wr_addr), 64'(8'(base + 8'(nwr))));
          checkOutput("wr_data", wr_data, exp_q[nwr]);
        end
        last_addr = wr_addr;
        nwr++;
      end
      if (done) begin
        ndone++;
        checkOutput("done_cycle", 64'(cyc), 64'd66);
        checkOutput("acc_clear_at_done", 64'(mul_acc_clear), 64'd1);
      end
    end
    start = 1'b0;
    if (!aborted) begin
      checkOutput("write_count", 64'(nwr), 64'd64);
      checkOutput("read_count", 64'(nrd), 64'd64);
      checkOutput("done_count", 64'(ndone), 64'd1);
    end
    for (int k = 0; k < nwr && k < 64; k++) ref_mem[8'(base + 8'(k))] = exp_q[k];
  endtask

  initial begin
    logic [63:0] obs0;
    logic [7:0]  last_addr;
    logic [7:0]  b;
    bit a, r, c;

    for (int i = 0; i < 256; i++) ref_mem[i] = 64'h0;
    for (int k = 0; k < 64; k++) coef_tab[k] = 64'h0;

    #1;
    checkOutput("reset_wr_en", 64'(wr_en), 64'd0);
    checkOutput("reset_mul_read", 64'(mul_read), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_wr_data", wr_data, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(0, 0, 0, 8'h10, 1, 1, 64'h0ABC_1000_0001_1FFF, -1, obs0, last_addr);
    checkOutput("overwrite_word0", obs0, 64'h0ABC_1000_0001_1FFF);
    checkOutput("overwrite_last_addr", 64'(last_addr), 64'h4F);

    applyStimulus(0, 0, 0, 8'h40, 1, 1, {16'h0000, 16'h0008, 16'h0800, 16'h0002}, -1, obs0, last_addr);
    applyStimulus(1, 0, 0, 8'h40, 1, 1, {16'h0000, 16'h0000, 16'h0800, 16'h1FFF}, -1, obs0, last_addr);
    checkOutput("acc_wrap_lane0", 64'(obs0[15:0]), 64'h0001);
    checkOutput("acc_wrap_lane1", 64'(obs0[31:16]), 64'h1000);

    applyStimulus(0, 0, 0, 8'h80, 1, 1, {16'h0000, 16'h0000, 16'h0000, 16'h0008}, -1, obs0, last_addr);
    applyStimulus(1, 1, 0, 8'h80, 1, 1, {16'h0000, 16'h0000, 16'h1FFE, 16'h0004}, -1, obs0, last_addr);
    checkOutput("round_lane0", 64'(obs0[15:0]), 64'h0002);
    checkOutput("round_wrap_lane1", 64'(obs0[31:16]), 64'h0000);

    applyStimulus(0, 0, 1, 8'hC0, 1, 1, {16'h0000, 16'h0000, 16'hFFFF, 16'h0001}, -1, obs0, last_addr);
    checkOutput("c10_mask_lane1", 64'(obs0[31:16]), 64'h03FF);
    applyStimulus(1, 0, 1, 8'hC0, 1, 1, {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, -1, obs0, last_addr);
    checkOutput("c10_acc_lane0", 64'(obs0[15:0]), 64'h0000);

    applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 8'hF0, 1, 0, 64'h0, -1, obs0, last_addr);
    checkOutput("wrap_last_addr", 64'(last_addr), 64'h2F);

    @(negedge clk);
    mul_done = 1'b0;
    start    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("nodone_mul_read", 64'(mul_read), 64'd0);
      checkOutput("nodone_wr_en", 64'(wr_en), 64'd0);
    end
    start    = 1'b0;
    mul_done = 1'b1;

    a = 1'($urandom); r = 1'($urandom); c = 1'($urandom); b = 8'($urandom);
    applyStimulus(a, r, c, b, 1, 0, 64'h0, 20, obs0, last_addr);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("idle_after_abort", 64'(mul_read), 64'd0);
    end
    applyStimulus(a, r, c, b, 0, 0, 64'h0, -1, obs0, last_addr);

    for (int t = 0; t < 5; t++) begin
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1, 0, 64'h0, -1,
                    obs0, last_addr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/poly_acc_writeback.md
# poly_acc_writeback

Downstream stage of the 256-coefficient parallel polynomial multiplier. Once the multiplier reports completion, this block drains its 3328-bit accumulator four coefficients per cycle through the multiplier's `read` / `coeff4x_out` interface. In accumulate mode it adds each coefficient to the previously stored polynomial (matrix-vector row sum), optionally applies Saber rounding (add constant, shift right), and writes 64 words of 4×uint16 to BRAM.

## Interface
Parameters:
- `SHIFT`, default 3: right-shift applied when rounding (eq − ep).
- `ROUND_CONST`, default 4: constant added before the shift (h1).
- `ADDR_W`, default 8: BRAM address width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin writeback. Accepted only in IDLE with `mul_done`=1.
- `acc_mode`  in  1  1 = add the previously stored word; 0 = overwrite. Sampled at start.
- `round_en`  in  1  1 = apply rounding. Sampled at start.
- `coeff16`  in  1  lane width select: 1 = 10-bit lanes, 0 = 13-bit. Tied to the multiplier's `pol_load_coeff4x`. Sampled at start.
- `base_addr`  in  ADDR_W  BRAM base address. Sampled at start.
- `mul_done`  in  1  multiplier `pol_mul_done`.
- `mul_read`  out  1  drives the multiplier `read`; rotates its accumulator by 52 bits per cycle.
- `mul_acc_clear`  out  1  drives the multiplier `acc_clear`; 1-cycle pulse in DONE.
- `coeff4x_in`  in  64  multiplier `coeff4x_out`; lane i is bits [16i+15:16i].
- `prev_addr`  out  ADDR_W  BRAM read address; data returns 1 cycle later.
- `prev_rdata`  in  64  previously stored word.
- `wr_addr`  out  ADDR_W  BRAM write address.
- `wr_data`  out  64  4×uint16 result lanes.
- `wr_en`  out  1  write strobe.
- `done`  out  1  1-cycle pulse when the last word has been written.

## Operation
- Reset values: all outputs 0; state IDLE; word counter 0.
- FSM:
  - IDLE → RUN on `start && mul_done`. Latches the sampled modes and `base_addr` and clears the counter. `start` is ignored in every other case.
  - RUN, 64 cycles, counter k = 0..63:
    - `mul_read`=1.
    - Register the four lanes of `coeff4x_in` together with k.
    - `prev_addr = base_addr + k`.
    - At k=63 → DRAIN.
  - DRAIN, 2 cycles: `mul_read`=0. Flushes the 2-stage pipeline. → DONE.
  - DONE, 1 cycle: `done`=1, `mul_acc_clear`=1. → IDLE.
- Lane arithmetic, per lane, with W = 10 if `coeff16` else 13:
  - c = lane[W−1:0]; p = `prev_rdata` lane[W−1:0] if `acc_mode`, else 0.
  - s = (c + p) mod 2^W.
  - If `round_en`: r = ((s + ROUND_CONST) mod 2^W) >> SHIFT. Otherwise r = s.
  - Output lane is r zero-extended to 16 bits. Upper input bits above W are ignored.
- Word k is written to `base_addr + k`. Addresses wrap modulo 2^ADDR_W.
- When `acc_mode`=0, `prev_rdata` is don't-care, but `prev_addr` is still driven.
- Reset asserted mid-operation: FSM returns to IDLE immediately. `wr_en`, `mul_read`, and `done` drop asynchronously. Any partial writes already made stay as written.

## Timing
- Coefficients for word k are valid on `coeff4x_in` in the same RUN cycle that `mul_read`=1, and are sampled at that edge.
- Pipeline:
  - Stage 1 captures the lanes at RUN cycle k.
  - `prev_rdata` for word k is valid in cycle k+1.
  - Stage 2 registers the sum and rounding result.
  - `wr_en`, `wr_addr`, and `wr_data` are registered outputs for word k in cycle k+2.
- `wr_en` is high for exactly 64 consecutive cycles, starting 2 cycles after the first RUN cycle.
- Total from the `start` edge to the `done` pulse: 1 + 64 + 2 cycles. `done` coincides with the cycle after the last `wr_en`.
- Exactly 64 `mul_read` cycles, so the multiplier's accumulator completes one full rotation before `mul_acc_clear`.

## Structure
- Shared package `saber_wb_pkg`:
  - constants `N_COEFF`=256, `LANES`=4, `WORDS`=64, `EQ`=13, `EP`=10.
  - FSM state encoding.
- Sub-module `lane_round_add`: combinational per-lane add, mod, round and shift, parameterised by `SHIFT`/`ROUND_CONST`. Instantiated 4×.
- Top holds the FSM, counter, address generation, and the two pipeline register stages.

## Test plan
- Overwrite, 13-bit, no round: lanes 0x1FFF, 0x0001, 0x1000, 0x0ABC for word 0, with `base_addr`=0x10 → `wr_data`=0x0ABC_1000_0001_1FFF at address 0x10, 2 cycles after the first `mul_read`. 64 writes, then `done`.
- Accumulate wrap: c=0x1FFF, p=0x0002 → lane 0x0001. c=0x0800, p=0x0800 → 0x1000.
- Accumulate + round, 13-bit: c=0x0004, p=0x0008 → s=0x000C → (12+4)>>3 = 0x0002. c=0x1FFE, p=0 → (0x2002 mod 2^13)>>3 = 0x0000.
- 10-bit mode: lane input 0xFFFF → 0x03FF. With accumulate of p=0x0001 → 0x0000.
- Handshake and boundary:
  - `start` with `mul_done`=0 → no activity.
  - `start` during RUN → ignored.
  - `base_addr`=0xF0 → last write goes to address 0x2F (wrap).
- Reset at RUN k=20 → all outputs 0 next evaluation, state IDLE. A subsequent start replays all 64 words correctly.
